// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
// Handles the hazards that the forwarding network cannot resolve:
// load-use, data-memory busy and taken-branch flush. It sits beside the
// ID stage and drives the PC and IF/ID write enables, the bubble and flush
// controls, and a whole-pipeline freeze for multi-cycle memory accesses.
//
// Optional build macro: HAZARD_STALL_STATS_EN
//   When defined, stall_count is a saturating count of stalled cycles.
//   When undefined, stall_count is tied to zero and no counter is built.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | normal flow; a load-use hazard inserts the first bubble here
// STALL | load-use bubbles still owed; rem holds how many are left
module hazard_stall_unit #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ID_EX_MemRead,
  input  logic [4:0]           ID_EX_rt,
  input  logic [4:0]           IF_ID_rs,
  input  logic [4:0]           IF_ID_rt,
  input  logic                 IF_ID_UsesRt,
  input  logic                 mem_busy,
  input  logic                 branch_taken,
  output logic                 PC_Write,
  output logic                 IF_ID_Write,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Flush,
  output logic                 Pipe_Freeze,
  output logic [CNT_WIDTH-1:0] stall_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  // The first bubble is issued from IDLE, so STALL only covers the rest.
  localparam logic [3:0] REM_INIT = 4'(STALL_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] rem;
  logic [3:0] rem_nxt;
  logic       hazard;

  // Register $0 is hard-wired to zero, so a load into it never conflicts.
  assign hazard = ID_EX_MemRead
                & ((ID_EX_rt == IF_ID_rs) | (IF_ID_UsesRt & (ID_EX_rt == IF_ID_rt)))
                & (ID_EX_rt != 5'd0);

  // State register and remaining-bubble counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rem   <= 4'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  // Next-state and prioritised output decode: reset, mem_busy, branch, stall, normal.
  always_comb begin
    state_nxt   = state;
    rem_nxt     = rem;
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    Pipe_Freeze = 1'b0;
    if (reset) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      state_nxt   = IDLE;
      rem_nxt     = 4'd0;
    end else if (mem_busy) begin
      // Upstream holds branch/hazard inputs stable, so they are simply ignored here.
      Pipe_Freeze = 1'b1;
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
    end else if (branch_taken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
      state_nxt   = IDLE;
      rem_nxt     = 4'd0;
    end else if (state == STALL) begin
      // Bubbles continue regardless of the live hazard; the load has left ID/EX.
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      if (rem == 4'd1) begin
        state_nxt = IDLE;
        rem_nxt   = 4'd0;
      end else begin
        rem_nxt = rem - 4'd1;
      end
    end else if (hazard) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Flush = 1'b1;
      if (STALL_CYCLES > 1) begin
        state_nxt = STALL;
        rem_nxt   = REM_INIT;
      end
    end
  end

`ifdef HAZARD_STALL_STATS_EN
  // Saturating count of cycles in which the PC was held (load-use or mem_busy).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (!PC_Write && (stall_count != {CNT_WIDTH{1'b1}})) begin
      stall_count <= stall_count + CNT_WIDTH'(1);
    end
  end
`else
  assign stall_count = '0;
`endif

endmodule
